instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//   Writer side of the nibble-organised instruction memory.
//   - Accepts WORD_LEN-bit instruction words over a valid/ready stream.
//   - Writes each word into consecutive MEM_CELL_SIZE-bit cells, most significant nibble
//     first at the lowest address, matching the read-side assembly
//     {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
//   - Sits between the testbench/boot source and the memory write port; holds busy while
//     loading so the pipeline can be held off.
// PARAMETERS
//   WORD_LEN       16   instruction width in bits (from defines.v)
//   MEM_CELL_SIZE  4    memory cell width in bits (from defines.v)
//   INSTR_MEM_SIZE 64   number of cells; power of two, >= 4 (from defines.v)
//   NPW            WORD_LEN/MEM_CELL_SIZE = 4, cells per word (derived localparam)
// PORTS
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous, active-high reset
//   start      in   1              begin a load session; sampled only in IDLE
//   base_addr  in   AW             first cell address, AW=$clog2(INSTR_MEM_SIZE); low 2 bits forced to 0
//   in_valid   in   1              in_word/in_last valid
//   in_ready   out  1              loader can accept a word this cycle
//   in_word    in   WORD_LEN       instruction to store
//   in_last    in   1              this word ends the session
//   mem_we     out  1              cell write strobe
//   mem_addr   out  AW             cell address
//   mem_wdata  out  MEM_CELL_SIZE  cell data
//   busy       out  1              high in ACCEPT/WRITE
//   done       out  1              one-cycle pulse when a session completes normally
//   overflow   out  1              sticky: memory end reached before in_last
//   word_count out  AW             words written in current/last session
// BEHAVIOUR
//   Reset: state=IDLE. in_ready, mem_we, busy, done, overflow = 0; mem_addr, mem_wdata,
//     word_count = 0. rst mid-session aborts on the next edge; no further writes issue.
//   States:
//     IDLE   : start=1 -> ptr<=base_addr & ~3, word_count<=0, overflow<=0 -> ACCEPT.
//              start is ignored in every other state.
//     ACCEPT : in_ready=1, busy=1. On in_valid&in_ready: latch word and last, nib<=0 -> WRITE.
//     WRITE  : in_ready=0, busy=1, mem_we=1, mem_addr=ptr+nib,
//              mem_wdata=word[WORD_LEN-1-nib*MEM_CELL_SIZE -: MEM_CELL_SIZE]. nib++ each cycle.
//              On nib==NPW-1: ptr<=ptr+NPW, word_count++, then:
//                last=1                              -> DONE
//                else ptr+NPW wraps to 0 (memory end) -> ERR
//                else                                -> ACCEPT
//     DONE   : done=1 for exactly one cycle -> IDLE.
//     ERR    : overflow=1, busy=0, in_ready=0. -> IDLE on the next cycle; overflow stays set
//              until rst or the next accepted start.
//     If last=1 and memory end coincide, DONE wins; overflow stays 0.
//   Timing:
//     - Word handshake in cycle N -> nibble writes in cycles N+1..N+4.
//     - Next in_ready in cycle N+5; throughput is 1 word per 5 cycles.
//     - Outputs are registered; mem_* change only on clock edges.
//     - mem_we=0 outside WRITE; mem_addr and mem_wdata hold their last value when idle.
//   Address arithmetic is modulo INSTR_MEM_SIZE; no write ever targets an index >= INSTR_MEM_SIZE.
//   in_word is captured only on handshake. Changing it while ready=0 has no effect.
// STRUCTURE
//   defines.v gets:
//     - NPW
//     - state codes LDR_IDLE/LDR_ACCEPT/LDR_WRITE/LDR_DONE/LDR_ERR (3-bit)
//     - existing WORD_LEN, MEM_CELL_SIZE, INSTR_MEM_SIZE
//   Sub-module word_nibble_serializer:
//     - holds the latched word and nib counter
//     - emits the nibble and a last_nib flag
//   The FSM and pointer logic stay in this module.
// TESTING
//   1. rst held 2 cycles -> all outputs 0, state IDLE. in_valid=1 without start -> in_ready stays 0.
//   2. start, base_addr=8, one word 16'h310A with last=1 -> writes (8,3)(9,1)(10,0)(11,A) on
//      4 consecutive cycles; done pulse 1 cycle; word_count=1.
//   3. base_addr=10 (misaligned) with two words 16'h3C0F and 16'h7A5E, the second with
//      last=1 -> cells 8..15 = 3,C,0,F,7,A,5,E; in_ready gaps of exactly 4 cycles.
//   4. INSTR_MEM_SIZE=64, base_addr=60, two words, last on the second -> first word written
//      to 60..63, then ERR, overflow=1, no write to cell 0, done never pulses.
//   5. in_valid toggled randomly during WRITE -> no extra handshake; data captured only in
//      ACCEPT. start pulsed mid-session is ignored.
//   6. rst asserted on the 2nd nibble cycle -> mem_we=0 from the next edge; a restart with
//      base_addr=0 loads normally, with overflow=0 and word_count=0 at start.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Parameter defaults mirror the core's instruction and memory geometry.
package instr_mem_loader_pkg;

  localparam int WORD_LEN_DEF       = 16;
  localparam int MEM_CELL_SIZE_DEF  = 4;
  localparam int INSTR_MEM_SIZE_DEF = 64;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_ACCEPT = 3'd1,
    LDR_WRITE  = 3'd2,
    LDR_DONE   = 3'd3,
    LDR_ERR    = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/instr_mem_loader_serializer.sv
// Holds one latched instruction word and presents it one cell at a time,
// most significant cell first; last_nib_o marks the final cell of the word.
module word_nibble_serializer #(
  parameter int WORD_LEN = 16,
  parameter int CELL_W   = 4,
  parameter int NPW      = WORD_LEN / CELL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                advance_i,
  input  logic [WORD_LEN-1:0] word_i,
  output logic [CELL_W-1:0]   nibble_o,
  output logic                last_nib_o
);

  localparam int NIB_W = (NPW > 1) ? $clog2(NPW) : 1;

  logic [WORD_LEN-1:0] shreg_q;
  logic [NIB_W-1:0]    nib_q;

  // The output cell is always the top of the shift register, so it is a register output.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      nib_q   <= '0;
    end else if (load_i) begin
      shreg_q <= word_i;
      nib_q   <= '0;
    end else if (advance_i) begin
      shreg_q <= shreg_q << CELL_W;
      nib_q   <= nib_q + NIB_W'(1);
    end
  end

  assign nibble_o   = shreg_q[WORD_LEN-1 -: CELL_W];
  assign last_nib_o = (nib_q == NIB_W'(NPW - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Writer side of the nibble-organised instruction memory: takes words over a
// valid/ready stream and writes them as consecutive cells, MS cell at the lowest address.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int WORD_LEN       = WORD_LEN_DEF,
  parameter int MEM_CELL_SIZE  = MEM_CELL_SIZE_DEF,
  parameter int INSTR_MEM_SIZE = INSTR_MEM_SIZE_DEF,
  localparam int AW            = $clog2(INSTR_MEM_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [AW-1:0]            base_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_LEN-1:0]      in_word,
  input  logic                     in_last,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [MEM_CELL_SIZE-1:0] mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow,
  output logic [AW-1:0]            word_count
);

  localparam int            NPW        = WORD_LEN / MEM_CELL_SIZE;
  localparam logic [AW-1:0] ALIGN_MASK = AW'(NPW - 1);
  localparam logic [AW-1:0] NPW_A      = AW'(NPW);

  ldr_state_e    state_q;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] wcnt_q;
  logic          last_q;
  logic          in_ready_q;
  logic          we_q;
  logic          busy_q;
  logic          done_q;
  logic          ovf_q;

  logic [AW-1:0] ptr_d;
  logic          wrap_d;
  logic          hs;
  logic          ser_adv;
  logic          last_nib;

  assign hs      = in_valid & in_ready_q;
  assign ser_adv = (state_q == LDR_WRITE) & ~last_nib;
  assign ptr_d   = ptr_q + NPW_A;
  // The next word would start past the last cell when the pointer wraps to zero.
  assign wrap_d  = (ptr_d == '0);

  word_nibble_serializer #(
    .WORD_LEN (WORD_LEN),
    .CELL_W   (MEM_CELL_SIZE),
    .NPW      (NPW)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hs),
    .advance_i  (ser_adv),
    .word_i     (in_word),
    .nibble_o   (mem_wdata),
    .last_nib_o (last_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LDR_IDLE;
      ptr_q      <= '0;
      addr_q     <= '0;
      wcnt_q     <= '0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        LDR_IDLE: begin
          if (start) begin
            ptr_q      <= base_addr & ~ALIGN_MASK;
            wcnt_q     <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= LDR_ACCEPT;
          end
        end
        LDR_ACCEPT: begin
          if (hs) begin
            last_q     <= in_last;
            in_ready_q <= 1'b0;
            we_q       <= 1'b1;
            addr_q     <= ptr_q;
            state_q    <= LDR_WRITE;
          end
        end
        LDR_WRITE: begin
          if (last_nib) begin
            we_q   <= 1'b0;
            ptr_q  <= ptr_d;
            wcnt_q <= wcnt_q + AW'(1);
            // A final word that exactly fills memory completes normally.
            if (last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= LDR_DONE;
            end else if (wrap_d) begin
              busy_q  <= 1'b0;
              ovf_q   <= 1'b1;
              state_q <= LDR_ERR;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= LDR_ACCEPT;
            end
          end else begin
            addr_q <= addr_q + AW'(1);
          end
        end
        LDR_DONE: state_q <= LDR_IDLE;
        LDR_ERR:  state_q <= LDR_IDLE;
        default:  state_q <= LDR_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized sessions for instr_mem_loader, compared against a
// list-of-writes model built from the cell layout rules.
module tb_instr_mem_loader;

  localparam int WL  = 16;
  localparam int CS  = 4;
  localparam int MS  = 64;
  localparam int AW  = 6;
  localparam int NPW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [WL-1:0] in_word;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [CS-1:0] mem_wdata;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW-1:0] word_count;

  instr_mem_loader #(
    .WORD_LEN       (WL),
    .MEM_CELL_SIZE  (CS),
    .INSTR_MEM_SIZE (MS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .in_last    (in_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed write stream and done-pulse bookkeeping
  logic [AW+CS-1:0] wr_q[$];
  int               wcyc_q[$];
  logic [CS-1:0]    tb_mem[MS];
  bit               wflag[MS];
  int               done_cnt = 0;
  int               done_dbl = 0;
  bit               prev_done = 1'b0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_q.push_back({mem_addr, mem_wdata});
      wcyc_q.push_back(cyc);
      tb_mem[mem_addr] = mem_wdata;
      wflag[mem_addr]  = 1'b1;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (prev_done) done_dbl++;
    end
    prev_done = (done === 1'b1);
  end

  // Reference model state
  logic [WL-1:0]    words[8];
  int               hs_q[$];
  logic [AW+CS-1:0] exp_q[$];
  bit               exp_ovf;
  int               exp_wc;
  int               exp_done;
  bit               ovf_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected writes: word i occupies cells aligned_base+4i .. +3, MS cell first;
  // the session stops after the word marked last, or when the next word would pass the end.
  task automatic model(input int base, input int nw);
    int p;
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_done = 0;
    exp_wc   = 0;
    p = base - (base % NPW);
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < NPW; k++)
        exp_q.push_back({AW'((p + NPW * i + k) % MS), CS'(words[i] >> (WL - CS * (k + 1)))});
      exp_wc = i + 1;
      if (i == nw - 1) begin
        exp_done = 1;
        break;
      end
      if (p + NPW * (i + 1) >= MS) begin
        exp_ovf = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_word(input logic [WL-1:0] w, input bit last, input bit rnd, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 60) begin
      if (in_ready === 1'b1) begin
        if (rnd && $urandom_range(3) == 0) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_word  = w;
          in_last  = last;
          start    = 1'b0;
          hs_q.push_back(cyc);
          ok = 1'b1;
          break;
        end
      end else if (rnd) begin
        in_valid  = 1'($urandom_range(1));
        in_word   = WL'($urandom);
        in_last   = 1'($urandom_range(1));
        start     = 1'($urandom_range(1));
        base_addr = AW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
      end
      @(negedge clk);
      n++;
    end
    if (!ok) check("handshake_timeout", 32'(ok), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_session(input int base, input int nw, input bit rnd, input string tag);
    bit ok;
    int j;
    wr_q.delete();
    wcyc_q.delete();
    hs_q.delete();
    done_cnt = 0;
    done_dbl = 0;
    model(base, nw);
    check({tag, "_ovf_before_start"}, 32'(overflow), 32'(ovf_prev));
    start     = 1'b1;
    base_addr = AW'(base);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready_after_start"}, 32'(in_ready), 32'(1));
    check({tag, "_busy_after_start"}, 32'(busy), 32'(1));
    check({tag, "_wc_after_start"}, 32'(word_count), 32'(0));
    check({tag, "_ovf_after_start"}, 32'(overflow), 32'(0));
    for (int i = 0; i < exp_wc; i++) begin
      send_word(words[i], (i == nw - 1), rnd, ok);
      if (!ok) break;
    end
    repeat (6) @(negedge clk);
    if (exp_ovf) begin
      in_valid = 1'b1;
      in_word  = words[exp_wc];
      in_last  = 1'b1;
      j = 0;
      repeat (8) begin
        @(negedge clk);
        if (in_ready === 1'b1) j++;
      end
      in_valid = 1'b0;
      check({tag, "_no_accept_after_ovf"}, 32'(j), 32'(0));
    end
    check({tag, "_write_count"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      check({tag, "_write_addr_data"}, 32'(wr_q[k]), 32'(exp_q[k]));
      if (k / NPW < hs_q.size())
        check({tag, "_write_cycle"}, 32'(wcyc_q[k]), 32'(hs_q[k / NPW] + 1 + k % NPW));
    end
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_done_width"}, 32'(done_dbl), 32'(0));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_word_count"}, 32'(word_count), 32'(exp_wc));
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    check({tag, "_idle_we"}, 32'(mem_we), 32'(0));
    ovf_prev = exp_ovf;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int nw;
    int b;
    logic [AW+CS-1:0] e;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    in_valid  = 1'b0;
    in_word   = '0;
    in_last   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    check("rst_word_count", 32'(word_count), 32'(0));
    rst = 1'b0;
    in_valid = 1'b1;
    in_word  = 16'h1234;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0) cnt++;
    end
    in_valid = 1'b0;
    check("idle_no_ready", 32'(cnt), 32'(0));
    check("idle_no_writes", 32'(wr_q.size()), 32'(0));

    // Single word at an aligned base
    words[0] = 16'h310A;
    run_session(8, 1, 1'b0, "single");
    if (wr_q.size() == 4) begin
      e = {6'd8, 4'h3};
      check("single_first_cell", 32'(wr_q[0]), 32'(e));
      e = {6'd11, 4'hA};
      check("single_last_cell", 32'(wr_q[3]), 32'(e));
    end else begin
      check("single_size", 32'(wr_q.size()), 32'(4));
    end

    // Misaligned base, two words, back-to-back offers
    words[0] = 16'h3C0F;
    words[1] = 16'h7A5E;
    run_session(10, 2, 1'b0, "misaligned");
    if (hs_q.size() == 2) check("misaligned_hs_gap", 32'(hs_q[1] - hs_q[0]), 32'(5));
    else check("misaligned_hs_count", 32'(hs_q.size()), 32'(2));
    check("cell8", 32'(tb_mem[8]), 32'h3);
    check("cell9", 32'(tb_mem[9]), 32'hC);
    check("cell10", 32'(tb_mem[10]), 32'h0);
    check("cell11", 32'(tb_mem[11]), 32'hF);
    check("cell12", 32'(tb_mem[12]), 32'h7);
    check("cell13", 32'(tb_mem[13]), 32'hA);
    check("cell14", 32'(tb_mem[14]), 32'h5);
    check("cell15", 32'(tb_mem[15]), 32'hE);

    // End-of-memory overflow
    for (int i = 0; i < MS; i++) wflag[i] = 1'b0;
    words[0] = 16'hD1C2;
    words[1] = 16'hB3A4;
    run_session(60, 2, 1'b0, "overflow");
    check("overflow_no_cell0", 32'(wflag[0]), 32'(0));

    // Randomized sessions with noisy valid/start while the loader is writing
    for (int s = 0; s < 8; s++) begin
      nw = $urandom_range(1, 6);
      b  = $urandom_range(0, MS - 1);
      for (int i = 0; i < nw; i++) words[i] = WL'($urandom);
      run_session(b, nw, 1'b1, "random");
    end

    // Reset on the second cell write, then a clean restart
    wr_q.delete();
    words[0] = 16'hBEEF;
    start     = 1'b1;
    base_addr = AW'(20);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_word  = words[0];
    in_last  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_write_count", 32'(wr_q.size()), 32'(2));
    if (wr_q.size() >= 2) begin
      e = {6'd20, 4'hB};
      check("abort_cell0", 32'(wr_q[0]), 32'(e));
      e = {6'd21, 4'hE};
      check("abort_cell1", 32'(wr_q[1]), 32'(e));
    end
    ovf_prev = 1'b0;
    words[0] = 16'h0F1E;
    words[1] = 16'h2D3C;
    words[2] = 16'h4B5A;
    run_session(0, 3, 1'b0, "restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
